// File: rtl/pr_ctrl.sv
// pr_ctrl: sequences a partial-reconfiguration IP: start, stream len words, await status, report done/err.
// Define PR_CTRL_TIMEOUT_EN to add a no-progress watchdog (err_code 4 after TIMEOUT_CYC idle cycles).
module pr_ctrl #(
    parameter int LEN_W       = 20,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             pr_start,
    output logic [15:0]      pr_data,
    output logic             pr_data_valid,
    input  logic             pr_data_ready,
    input  logic [2:0]       pr_status,
    input  logic             pr_freeze,
    output logic             region_freeze,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code
);
    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, DONE, ERROR} state_t;
    state_t state, state_n;
    logic [LEN_W-1:0] cnt;
    logic [2:0] code_n;
    logic act, ip_err, tmo, pass, xfer, err_set;

    assign act           = state == START || state == STREAM || state == WAIT_DONE;
    assign ip_err        = act && pr_status inside {3'd1, 3'd2, 3'd3};
    // An IP error or timeout in the same cycle blocks the handshake so no word is lost.
    assign pass          = state == STREAM && cnt != '0 && !ip_err && !tmo;
    assign xfer          = pass && src_valid && pr_data_ready;
    assign src_ready     = pass && pr_data_ready;
    assign pr_data_valid = pass && src_valid;
    assign pr_data       = src_data;
    assign pr_start      = state == START;
    assign busy          = act;

    always_comb begin
        state_n = state;
        code_n  = 3'd5;
        err_set = 1'b0;
        case (state)
            START:     state_n = pr_status == 3'b100 ? STREAM : START;
            STREAM:    state_n = xfer && cnt == LEN_W'(1) ? WAIT_DONE : STREAM;
            WAIT_DONE: state_n = pr_status == 3'b101 ? DONE : WAIT_DONE;
            default: begin
                state_n = req ? (len != '0 ? START : ERROR) : (state == DONE || state == ERROR) ? state : IDLE;
                err_set = req && len == '0;
            end
        endcase
        if (ip_err) begin
            state_n = ERROR;
            err_set = 1'b1;
            code_n  = pr_status;
        end else if (tmo) begin
            state_n = ERROR;
            err_set = 1'b1;
            code_n  = 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 3'd0;
            region_freeze <= 1'b0;
        end else begin
            state         <= state_n;
            region_freeze <= pr_freeze | act;
            if (!act && req) begin
                cnt      <= len;
                done     <= 1'b0;
                err      <= 1'b0;
                err_code <= 3'd0;
            end else if (xfer) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (err_set) begin
                err      <= 1'b1;
                err_code <= code_n;
                done     <= 1'b0;
            end
            if (state == WAIT_DONE && state_n == DONE) done <= 1'b1;
        end
    end

`ifdef PR_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
    logic [2:0] status_q;

    assign tmo = act && !ip_err && wd == WD_W'(TIMEOUT_CYC - 1);

    // Any sign of progress (state change, transfer, status change) restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd       <= '0;
            status_q <= 3'd0;
        end else begin
            status_q <= pr_status;
            wd       <= (!act || state_n != state || xfer || pr_status != status_q) ? '0
                      : wd == WD_W'(TIMEOUT_CYC) ? wd : wd + WD_W'(1);
        end
    end
`else
    assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_pr_ctrl.sv
// tb_pr_ctrl: randomized scoreboard bench for pr_ctrl with a behavioural source and IP model.
module tb_pr_ctrl;
    localparam int TMO = 16;
`ifdef PR_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        logic       d;
        logic       e;
        logic [2:0] c;
        int         st;
    } res_t;

    logic clk = 1'b0;
    logic rst, req, src_valid, src_ready, pr_start, pr_data_valid, pr_data_ready;
    logic pr_freeze, region_freeze, busy, done, err;
    logic [19:0] len;
    logic [15:0] src_data, pr_data;
    logic [2:0] pr_status, err_code;

    pr_ctrl #(.LEN_W(20), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .pr_start(pr_start), .pr_data(pr_data), .pr_data_valid(pr_data_valid),
        .pr_data_ready(pr_data_ready), .pr_status(pr_status), .pr_freeze(pr_freeze),
        .region_freeze(region_freeze), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, results_seen = 0, st_seen = 0;
    int op_len, got, err_k, st_lat, st_cnt, dn_lat, dn_cnt, poke_at, rmode, cyc;
    bit poked, vmode, acc, ps, prv_busy, prv_frz, prv_rst, zl_pend;
    logic [2:0] err_v;
    logic [3:0] rpat = 4'b1001;
    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];
    res_t res_q[$];

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // Handshake and pr_start as seen at the clock edge, for the source/IP model.
    always @(posedge clk) begin
        acc <= !rst && src_valid && src_ready;
        ps  <= !rst && pr_start;
    end

    // Monitor: pops expected words on every handshake and expected outcome when an operation ends.
    always @(negedge clk) begin
        res_t r;
        if (!rst) begin
            if (!prv_rst) chk("region_freeze", 32'(region_freeze), 32'(prv_frz | prv_busy));
            if (!busy) chk("idle_handshake", 32'({src_ready, pr_data_valid}), 32'd0);
            if (pr_start) st_seen++;
            if (src_valid && src_ready) begin
                chk("pr_data_valid", 32'(pr_data_valid), 32'd1);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %h, none expected", pr_data);
                end else begin
                    chk("word", 32'(pr_data), 32'(exp_q.pop_front()));
                end
            end
            if ((prv_busy && !busy && !prv_rst) || zl_pend) begin
                if (res_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: done=%0b err=%0b code=%0d", done, err, err_code);
                end else begin
                    r = res_q.pop_front();
                    chk("done", 32'(done), 32'(r.d));
                    chk("err", 32'(err), 32'(r.e));
                    chk("err_code", 32'(err_code), 32'(r.c));
                    chk("pr_start_cycles", st_seen, r.st);
                    chk("words_missing", exp_q.size(), 0);
                end
                exp_q.delete();
                results_seen++;
            end
            zl_pend = req && !busy && len == 20'd0;
            if (req && !busy) st_seen = 0;
        end else begin
            zl_pend = 1'b0;
            st_seen = 0;
        end
        prv_busy = busy;
        prv_frz  = pr_freeze;
        prv_rst  = rst;
    end

    task automatic drive();
        src_valid     = src_q.size() != 0 && (vmode || $urandom_range(0, 9) < 8);
        src_data      = src_q.size() != 0 ? src_q[0] : 16'($urandom);
        pr_data_ready = rmode == 2 ? rpat[cyc % 4] : rmode == 1 ? 1'b1 : ($urandom_range(0, 9) < 8);
        pr_freeze     = $urandom_range(0, 3) == 0;
    endtask

    // One clock of the source and IP model: consume handshaken words, answer with status.
    task automatic step();
        @(posedge clk);
        #1;
        req = 1'b0;
        cyc++;
        if (acc) begin
            src_q.delete(0);
            got++;
            if (got == err_k) pr_status = err_v;
        end
        if (ps && st_lat != 0) begin
            st_cnt++;
            if (st_cnt == st_lat) pr_status = 3'b100;
        end
        if (op_len != 0 && got == op_len && err_k == 0) begin
            dn_cnt++;
            if (dn_cnt == dn_lat) pr_status = 3'b101;
        end
        if (poke_at != 0 && got == poke_at && !poked) begin
            poked = 1'b1;
            req   = 1'b1;
            len   = 20'($urandom_range(0, 15));
        end
        drive();
    endtask

    // n words, IP error ev after k words (k=0: none), IP starts after sl pr_start cycles (0: never).
    task automatic start_op(int n, int k, logic [2:0] ev, int sl, int dl, bit vm, int rm, int extra, int pk, int seq);
        res_t r;
        int nw;
        src_q.delete();
        for (int i = 0; i < n + extra; i++) src_q.push_back(seq != 0 ? 16'(seq * (i + 1)) : 16'($urandom));
        nw = (n == 0 || sl == 0) ? 0 : k != 0 ? k : n;
        for (int i = 0; i < nw; i++) exp_q.push_back(src_q[i]);
        r.d  = n != 0 && sl != 0 && k == 0;
        r.e  = !r.d;
        r.c  = n == 0 ? 3'd5 : sl == 0 ? 3'd4 : k != 0 ? ev : 3'd0;
        r.st = n == 0 ? 0 : sl == 0 ? TMO : sl + 1;
        if (n == 0 || sl != 0 || TMO_EN) res_q.push_back(r);
        op_len = n; got = 0; err_k = k; err_v = ev; st_lat = sl; st_cnt = 0;
        dn_lat = dl; dn_cnt = 0; vmode = vm; rmode = rm; cyc = 0; poke_at = pk; poked = 1'b0;
        pr_status = 3'd0;
        req = 1'b1;
        len = 20'(n);
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete(); res_q.delete(); src_q.delete();
        op_len = 0; err_k = 0; st_lat = 0; poke_at = 0;
        pr_status = 3'd0;
        drive();
    endtask

    task automatic wait_op();
        int base = results_seen;
        for (int i = 0; i < 300 && results_seen == base; i++) step();
        if (results_seen == base) begin
            vectors++;
            miscompares++;
            $display("FAIL op_timeout: busy=%0b done=%0b err=%0b after 300 cycles, result required", busy, done, err);
            do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k;
        rst = 1'b1; req = 1'b0; len = '0; pr_status = 3'd0;
        op_len = 0; got = 0; err_k = 0; st_lat = 0; poke_at = 0; vmode = 1'b0; rmode = 1; cyc = 0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({pr_start, pr_data_valid, src_ready, region_freeze, busy, done, err, err_code}), 32'd0);
        step();

        start_op(4, 0, 3'd0, 2, 3, 1'b1, 1, 0, 0, 16'h1111);
        wait_op();

        start_op(3, 0, 3'd0, 1, 2, 1'b0, 2, 1, 0, 0);
        wait_op();
        chk("bp_words_left", src_q.size(), 1);

        start_op(8, 5, 3'd2, 2, 2, 1'b1, 1, 0, 0, 0);
        wait_op();
        chk("crc_words_left", src_q.size(), 3);
        chk("crc_src_ready", 32'(src_ready), 32'd0);

        start_op(0, 0, 3'd0, 1, 1, 1'b1, 1, 2, 0, 0);
        wait_op();
        chk("zero_words_left", src_q.size(), 2);

        start_op(6, 0, 3'd0, 1, 2, 1'b1, 1, 0, 3, 0);
        wait_op();

        start_op(8, 0, 3'd0, 1, 2, 1'b1, 1, 0, 0, 0);
        for (int i = 0; i < 100 && got < 3; i++) step();
        do_reset();
        @(negedge clk);
        chk("rst_outputs", 32'({pr_start, pr_data_valid, src_ready, region_freeze, busy, done, err, err_code}), 32'd0);
        step();

        start_op(2, 0, 3'd0, 0, 1, 1'b1, 1, 0, 0, 0);
`ifdef PR_CTRL_TIMEOUT_EN
        wait_op();
`else
        repeat (40) step();
        chk("stuck_in_start", 32'({pr_start, busy}), 32'd3);
        do_reset();
`endif

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 8);
            k = (n != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            start_op(n, k, 3'($urandom_range(1, 3)), $urandom_range(1, 3), $urandom_range(1, 3),
                     1'b0, 0, $urandom_range(0, 2), 0, 0);
            wait_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
